// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: ALU op encoding, opcode/funct constants and the
// request-to-instruction encoder used by the program loader.
package riscv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } aluop_e;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] F7_ALT = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    typedef struct packed {
        logic [31:0] word;
        logic        illegal;
    } enc_t;

    // There is no SUBI in RV32I, so an immediate SUB is rejected as illegal.
    function automatic enc_t encode_instr(
        input logic [3:0]  aluop,
        input logic        sel_b,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [11:0] imm
    );
        enc_t       res;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_shift;
        res      = '0;
        f3       = F3_ADD_SUB;
        f7       = 7'b0;
        is_shift = 1'b0;
        case (aluop)
            ALU_ADD:  f3 = F3_ADD_SUB;
            ALU_SUB:  begin f3 = F3_ADD_SUB; f7 = F7_ALT; res.illegal = sel_b; end
            ALU_SLL:  begin f3 = F3_SLL; is_shift = 1'b1; end
            ALU_SLT:  f3 = F3_SLT;
            ALU_SLTU: f3 = F3_SLTU;
            ALU_XOR:  f3 = F3_XOR;
            ALU_SRL:  begin f3 = F3_SR; is_shift = 1'b1; end
            ALU_SRA:  begin f3 = F3_SR; f7 = F7_ALT; is_shift = 1'b1; end
            ALU_OR:   f3 = F3_OR;
            ALU_AND:  f3 = F3_AND;
            default:  res.illegal = 1'b1;
        endcase
        if (!sel_b) begin
            res.word = {f7, rs2, rs1, f3, rd, OPC_R};
        end else if (is_shift) begin
            res.word = {f7, imm[4:0], rs1, f3, rd, OPC_I};
        end else begin
            res.word = {imm, rs1, f3, rd, OPC_I};
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO; pointers carry one extra wrap bit so
// full and empty are distinguished by comparing the MSBs.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; entries are only observed once written.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU-level requests into RV32I R/I-type words, buffers them and
// streams them into instruction memory at consecutive word addresses.
module instr_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_aluop,
    input  logic              in_sel_b,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              imem_wvalid,
    input  logic              imem_wready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic [15:0]       wr_cnt
);
    import riscv_pkg::*;

    enc_t              enc;
    logic              fifo_full, fifo_empty;
    logic [31:0]       fifo_head;
    logic              accept, push, pop, illegal_acc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;

    always_comb enc = encode_instr(in_aluop, in_sel_b, in_rd, in_rs1, in_rs2, in_imm);

    // A clear in the same cycle swallows both handshakes.
    assign in_ready    = !fifo_full;
    assign accept      = in_valid && in_ready && !clr;
    assign push        = accept && !enc.illegal;
    assign illegal_acc = accept && enc.illegal;
    assign imem_wvalid = !fifo_empty;
    assign pop         = imem_wvalid && imem_wready && !clr;
    assign imem_wdata  = fifo_empty ? 32'h0 : fifo_head;
    assign imem_addr   = addr_q;
    assign err         = err_q;
    assign err_cnt     = err_cnt_q;
    assign wr_cnt      = wr_cnt_q;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .din   (enc.word),
        .pop   (pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_comb begin
        addr_d    = addr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        if (clr) begin
            addr_d    = BASE_ADDR;
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
            wr_cnt_d  = 16'd0;
        end else begin
            if (pop) begin
                addr_d   = addr_q + ADDR_W'(4);
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
            if (illegal_acc) begin
                err_d = 1'b1;
                if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            wr_cnt_q  <= 16'd0;
        end else begin
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the instruction decoder. Accepts ALU-level operation requests (aluop, sel_b, register indices, immediate) and encodes each one into an RV32I R-type or I-type arithmetic instruction word.
- Encoded words are buffered in a small FIFO, then written to instruction memory at consecutive word addresses through a valid/ready write port.
- Serves as the on-chip program loader and self-test generator for the datapath.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- ADDR_W, 32, instruction-memory byte-address width.
- BASE_ADDR, 0, first write address after reset or clear.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: flush FIFO, reload address, clear error state.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid & in_ready.
- in_aluop  input  4  ALU op in the decoder's encoding.
- in_sel_b  input  1  0 = R-type (rs2), 1 = I-type (imm).
- in_rd  input  5  destination register.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2; ignored when sel_b = 1.
- in_imm  input  12  immediate; ignored when sel_b = 0.
- imem_wvalid  output  1  write valid.
- imem_wready  input  1  memory accepts the write.
- imem_addr  output  ADDR_W  byte address.
- imem_wdata  output  32  encoded instruction.
- err  output  1  sticky illegal-request flag.
- err_cnt  output  8  illegal-request count; saturates at 255.
- wr_cnt  output  16  count of completed writes; wraps.

Behaviour:
- Reset (rst_n low, asynchronous) and clr (synchronous):
  - FIFO empty.
  - imem_addr = BASE_ADDR.
  - imem_wvalid = 0, in_ready = 1, imem_wdata = 0.
  - err = 0, err_cnt = 0, wr_cnt = 0.
  - clr has priority over any same-cycle handshake; the handshake is discarded.
- ALU op encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - funct3 per op: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111.
- R-type (sel_b = 0):
  - word = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - funct7 = 7'b0100000 for SUB and SRA, 0 otherwise.
- I-type (sel_b = 1):
  - opcode 7'b0010011.
  - word = {imm[11:0], rs1, funct3, rd, opcode}.
  - Shifts SLL/SRL/SRA instead use {funct7, imm[4:0], rs1, funct3, rd, opcode}, with funct7 = 7'b0100000 only for SRA. imm[11:5] is ignored for shifts.
- Illegal requests:
  - Conditions: aluop > 9, or (sel_b = 1 & aluop = SUB).
  - The request is accepted (handshake completes) but not enqueued.
  - err is set; err_cnt increments, saturating at 255.
- Encoding happens at acceptance; the FIFO stores the finished 32-bit word.
- Input handshake:
  - in_ready = !full. There is no full-bypass: a pop and a push in the same cycle while full is impossible because in_ready = 0.
  - When not full, a push and a pop in the same cycle both occur and the count is unchanged.
- Latency: a word accepted into an empty FIFO appears on imem_wdata with imem_wvalid = 1 on the next cycle.
- Output handshake:
  - imem_wvalid = !empty. imem_wdata is the FIFO head; imem_addr is the current address register.
  - imem_addr and imem_wdata stay stable while imem_wvalid & !imem_wready.
  - On imem_wvalid & imem_wready: pop; imem_addr += 4 (mod 2^ADDR_W, wraps silently); wr_cnt += 1 (wraps).
- FIFO: circular buffer with read/write pointers of log2(DEPTH)+1 bits, giving full/empty by MSB compare.
- Asserting rst_n mid-transfer drops all pending words. No partial write is ever issued; the write port is single-beat.

Decomposition:
- Shared package `riscv_pkg`:
  - aluop_e enum, with the same values as the decoder.
  - OPC_R = 7'b0110011, OPC_I = 7'b0010011.
  - F7_ALT = 7'b0100000.
  - funct3 constants.
  - The decoder is to be migrated to this package too.
- Sub-module `sync_fifo` (params WIDTH, DEPTH):
  - push/pop/full/empty/head.
  - Reused later by the fetch stage.
- Encoding is a combinational function in the package: encode_instr(aluop, sel_b, rd, rs1, rs2, imm) returns {word, illegal}.

Test Plan:
- Reset, then ADD rd=3 rs1=1 rs2=2 with wready = 1 → one cycle later wvalid = 1, addr = 0x0, wdata = 0x002081B3; wr_cnt = 1.
- SUB rd=5 rs1=6 rs2=7, then ADDI rd=1 rs1=0 imm=0xFFF → writes 0x407302B3 at 0x0, then 0xFFF00093 at 0x4.
- SRAI rd=2 rs1=2 imm=0xFE3 → wdata = 0x40315113 (imm[11:5] ignored).
- Hold wready = 0 and push 5 requests with DEPTH = 4 → in_ready drops after the 4th; wdata and addr are stable. Release wready → 4 writes at addresses 0x0, 0x4, 0x8, 0xC in order, then the 5th is accepted.
- aluop = 12, then SUB with sel_b = 1 → both accepted, no write issued, err = 1, err_cnt = 2. clr → err = 0, err_cnt = 0, addr = BASE_ADDR.
- ADDR_W = 4, BASE_ADDR = 0xC: two writes → addr 0xC, then 0x0 (wrap). Pulse rst_n low with 2 words queued → wvalid = 0 immediately, FIFO empty.
